// File: rtl/reaction_pkg.sv
`default_nettype none
// ============================================================================
// Module : reaction_pkg
// Brief  : Shared FSM states, status codes and LFSR constants for reaction_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
package reaction_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_WAIT = 3'd2,
        ST_GO   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [1:0]  c_STATUS_OK      = 2'b00;
    localparam logic [1:0]  c_STATUS_FALSE   = 2'b01;
    localparam logic [1:0]  c_STATUS_TIMEOUT = 2'b10;

    localparam logic [31:0] c_LFSR_SEED = 32'hACE1_2468;
    localparam logic [31:0] c_LFSR_POLY = 32'h8020_0003;

endpackage
`default_nettype wire

// File: rtl/reaction_lfsr.sv
`default_nettype none
// ============================================================================
// Module : reaction_lfsr
// Brief  : 32-bit right-shifting Galois LFSR, free-running every cycle.
// Rev    : 1.0  initial release
// ============================================================================
module reaction_lfsr (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] q
);
    import reaction_pkg::*;

    logic [31:0] r_lfsr;

    // A non-zero seed keeps the register out of the all-zero lock-up state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= c_LFSR_SEED;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? c_LFSR_POLY : 32'd0);
        end
    end

    assign q = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/reaction_ctrl.sv
`default_nettype none
// ============================================================================
// Module : reaction_ctrl
// Brief  : Reaction-time trial controller; optional best-time tracking is
//          enabled by defining REACTION_CTRL_BEST_EN.
// Rev    : 1.0  initial release
// ============================================================================
module reaction_ctrl #(
    parameter logic [31:0] MIN_WAIT_CYC = 32'd50_000_000,
    parameter int unsigned RAND_W       = 26,
    parameter logic [31:0] TIMEOUT_CYC  = 32'd200_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        btn,
    input  logic [31:0] timer_val,
    output logic        timer_en,
    output logic        timer_clr,
    output logic        stim_led,
    output logic        busy,
    output logic [31:0] result,
    output logic [1:0]  status,
    output logic        result_valid,
    output logic [31:0] best_time
);
    import reaction_pkg::*;

    localparam logic [31:0] c_RAND_MASK =
        (RAND_W == 0) ? 32'd0 : (32'hFFFF_FFFF >> (32 - RAND_W));

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_btn_prev;
    logic        w_press;
    logic        w_timeout;
    logic [31:0] w_lfsr;
    logic [31:0] r_wait_cnt;
    logic [31:0] r_result;
    logic [1:0]  r_status;

    reaction_lfsr u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (w_lfsr)
    );

    assign w_press   = btn & ~r_btn_prev;
    assign w_timeout = (timer_val >= TIMEOUT_CYC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_btn_prev <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_btn_prev <= btn;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        timer_en     = 1'b0;
        timer_clr    = 1'b0;
        stim_led     = 1'b0;
        busy         = 1'b1;
        result_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) w_state_nxt = ST_ARM;
            end
            ST_ARM: begin
                timer_clr   = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            // Leaving on a count of one means GO starts as the counter hits zero.
            ST_WAIT: begin
                if (w_press)                 w_state_nxt = ST_DONE;
                else if (r_wait_cnt == 32'd1) w_state_nxt = ST_GO;
            end
            ST_GO: begin
                stim_led = 1'b1;
                timer_en = 1'b1;
                if (w_press || w_timeout) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                result_valid = 1'b1;
                w_state_nxt  = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= 32'd0;
            r_result   <= 32'd0;
            r_status   <= c_STATUS_OK;
        end else begin
            case (r_state)
                ST_ARM: r_wait_cnt <= MIN_WAIT_CYC + (w_lfsr & c_RAND_MASK);
                ST_WAIT: begin
                    r_wait_cnt <= r_wait_cnt - 32'd1;
                    if (w_press) begin
                        r_result <= 32'd0;
                        r_status <= c_STATUS_FALSE;
                    end
                end
                // A press wins over a timeout landing in the same cycle.
                ST_GO: begin
                    if (w_press) begin
                        r_result <= timer_val;
                        r_status <= c_STATUS_OK;
                    end else if (w_timeout) begin
                        r_result <= timer_val;
                        r_status <= c_STATUS_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign status = r_status;

`ifdef REACTION_CTRL_BEST_EN
    logic [31:0] r_best;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_best <= 32'hFFFF_FFFF;
        end else if (r_state == ST_DONE && r_status == c_STATUS_OK && r_result < r_best) begin
            r_best <= r_result;
        end
    end

    assign best_time = r_best;
`else
    assign best_time = 32'hFFFF_FFFF;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reaction_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_reaction_ctrl
// Brief  : Self-checking bench for reaction_ctrl against a trial-level model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_reaction_ctrl;

    localparam int c_MIN = 10;
    localparam int c_TO  = 100;
    localparam int c_GO  = c_MIN + 1;          // first GO cycle after start
    localparam int c_TTO = c_GO + c_TO;        // GO cycle where timer hits timeout

`ifdef REACTION_CTRL_BEST_EN
    localparam bit c_BEST_EN = 1'b1;
`else
    localparam bit c_BEST_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start, btn;
    logic [31:0] timer_val;
    logic        timer_en, timer_clr, stim_led, busy, result_valid;
    logic [31:0] result, best_time;
    logic [1:0]  status;

    logic        start4, btn4;
    logic [31:0] timer_val4;
    logic        timer_en4, timer_clr4, stim_led4, busy4, result_valid4;
    logic [31:0] result4, best_time4;
    logic [1:0]  status4;

    logic [31:0] m_lfsr;
    logic [31:0] m_best;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    reaction_ctrl #(.MIN_WAIT_CYC(32'd10), .RAND_W(0), .TIMEOUT_CYC(32'd100)) dut (
        .clk(clk), .rst(rst), .start(start), .btn(btn), .timer_val(timer_val),
        .timer_en(timer_en), .timer_clr(timer_clr), .stim_led(stim_led), .busy(busy),
        .result(result), .status(status), .result_valid(result_valid), .best_time(best_time)
    );

    reaction_ctrl #(.MIN_WAIT_CYC(32'd10), .RAND_W(4), .TIMEOUT_CYC(32'd100)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .btn(btn4), .timer_val(timer_val4),
        .timer_en(timer_en4), .timer_clr(timer_clr4), .stim_led(stim_led4), .busy(busy4),
        .result(result4), .status(status4), .result_valid(result_valid4), .best_time(best_time4)
    );

    // External timers driven by the DUT enables
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            timer_val <= 32'd0;
        else if (timer_clr) timer_val <= 32'd0;
        else if (timer_en)  timer_val <= timer_val + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             timer_val4 <= 32'd0;
        else if (timer_clr4) timer_val4 <= 32'd0;
        else if (timer_en4)  timer_val4 <= timer_val4 + 32'd1;
    end

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        logic [31:0] n;
        n = v >> 1;
        if (v[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 32'hACE1_2468;
        else     m_lfsr <= lfsr_next(m_lfsr);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One trial on the RAND_W=0 instance. p = cycle (0 = ARM) at which btn
    // rises, or <1 for no press. again = cycle with an extra start pulse, or -1.
    task automatic run_trial(input int p, input int again);
        int d, res, st;
        bit pressed;
        pressed = (p >= 1 && p <= c_TTO);
        d = pressed ? p + 1 : c_TTO + 1;
        if (pressed && p <= c_MIN) begin
            res = 0;      st = 1;
        end else if (pressed) begin
            res = p - c_GO; st = 0;
        end else begin
            res = c_TO;   st = 2;
        end
        start = 1'b1;
        for (int c = 0; c <= d + 1; c++) begin
            @(posedge clk); #1;
            start = (c == again);
            btn   = (p >= 1 && c >= p);
            chk("stim_led", 32'(stim_led), 32'(c > c_MIN && c < d));
            chk("busy", 32'(busy), 32'(c <= d));
            chk("result_valid", 32'(result_valid), 32'(c == d));
            if (c == d) begin
                chk("result", result, 32'(res));
                chk("status", 32'(status), 32'(st));
            end
        end
        if (st == 0 && 32'(res) < m_best) m_best = 32'(res);
        chk("best_time", best_time, c_BEST_EN ? m_best : 32'hFFFF_FFFF);
        start = 1'b0;
        btn   = 1'b0;
        @(posedge clk); #1;
    endtask

    // One no-press trial on the RAND_W=4 instance; measures the WAIT length.
    task automatic trial4();
        logic [31:0] exp_wait;
        int len;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        exp_wait = 32'd10 + (m_lfsr & 32'h0000_000F);
        chk("arm_clr4", 32'(timer_clr4), 32'd1);
        len = 0;
        forever begin
            @(posedge clk); #1;
            if (stim_led4 || len > 60) break;
            len++;
        end
        chk("wait_len4", 32'(len), exp_wait);
        chk("wait_range4", 32'(len >= 10 && len <= 25), 32'd1);
        for (int i = 0; i < 300 && busy4; i++) begin
            @(posedge clk); #1;
        end
        chk("idle4", 32'(busy4), 32'd0);
        chk("status4", 32'(status4), 32'd2);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_en"},    32'(timer_en),     32'd0);
        chk({tag, "_clr"},   32'(timer_clr),    32'd0);
        chk({tag, "_stim"},  32'(stim_led),     32'd0);
        chk({tag, "_busy"},  32'(busy),         32'd0);
        chk({tag, "_res"},   result,            32'd0);
        chk({tag, "_st"},    32'(status),       32'd0);
        chk({tag, "_valid"}, 32'(result_valid), 32'd0);
        chk({tag, "_best"},  best_time,         32'hFFFF_FFFF);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit saw_valid;
        int p;
        rst = 1'b1; start = 1'b0; btn = 1'b0; start4 = 1'b0; btn4 = 1'b0;
        m_best = 32'hFFFF_FFFF;
        #2;
        chk_reset_outputs("por");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Randomised wait lengths against the LFSR model, first three trials.
        repeat (3) trial4();

        run_trial(c_GO + 25, -1);           // ok, result 25
        run_trial(5, -1);                   // false start
        run_trial(0, -1);                   // timeout
        run_trial(c_GO + 30, 20);           // start during GO ignored

        // Reset in the middle of WAIT
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("mid_rst");
        m_best = 32'hFFFF_FFFF;
        @(negedge clk) rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (result_valid || busy) saw_valid = 1'b1;
        end
        chk("no_valid_after_rst", 32'(saw_valid), 32'd0);

        run_trial(c_GO + 40, -1);
        run_trial(c_GO + 25, -1);
        run_trial(c_GO + 60, -1);
        chk("best_of_three", best_time, c_BEST_EN ? 32'd25 : 32'hFFFF_FFFF);

        for (int k = 0; k < 8; k++) begin
            p = int'($urandom_range(0, c_TTO + 4));
            run_trial(p, -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
